// File: rtl/packet_pkg.sv
// Shared packet layout for the default 4-bit address / 8-bit data format.
package packet_pkg;

    localparam int PKT_ADDR_W = 4;
    localparam int PKT_DATA_W = 8;

    typedef struct packed {
        logic [PKT_ADDR_W-1:0] addr;
        logic [PKT_DATA_W-1:0] data;
    } packet_t;

    function automatic packet_t pack_pkt(input logic [PKT_ADDR_W-1:0] addr,
                                         input logic [PKT_DATA_W-1:0] data);
        packet_t p;
        p.addr = addr;
        p.data = data;
        return p;
    endfunction

endpackage

// File: rtl/pkt_fifo_core.sv
// First-word-fall-through FIFO: storage, wrapping pointers, occupancy count, full and empty.
module pkt_fifo_core #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Popped entries are left in place; only reset clears storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/packet_pack_fifo.sv
// Packs address/data pairs into packet words, buffers them in a FWFT FIFO, and flags overflow.
module packet_pack_fifo
    import packet_pkg::*;
#(
    parameter  int ADDR_W = 4,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PKT_W  = ADDR_W + DATA_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PKT_W-1:0]  out_pkt,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic              clear_ovf
);

    logic [PKT_W-1:0] wr_pkt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             overflow_q, overflow_d;

    // Default widths go through the shared struct layout; any other widths use plain concatenation.
    if (ADDR_W == PKT_ADDR_W && DATA_W == PKT_DATA_W) begin : g_default_pack
        packet_t pkt;
        assign pkt    = pack_pkt(in_addr, in_data);
        assign wr_pkt = pkt;
    end else begin : g_generic_pack
        assign wr_pkt = {in_addr, in_data};
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_addr  = out_pkt[PKT_W-1:DATA_W];
    assign out_data  = out_pkt[DATA_W-1:0];
    assign overflow  = overflow_q;

    pkt_fifo_core #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pkt),
        .rdata (out_pkt),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A rejected push in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_packet_pack_fifo.sv
// Directed self-checking bench for packet_pack_fifo at default widths and depth 4.
module tb_packet_pack_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_addr;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pkt;
    logic [3:0]  out_addr;
    logic [7:0]  out_data;
    logic [2:0]  count;
    logic        overflow;
    logic        clear_ovf;

    int compared   = 0;
    int mismatched = 0;

    logic        prev_stall;
    logic [3:0]  prev_addr;
    logic [7:0]  prev_data;
    logic [11:0] exp_q [$];
    logic [11:0] exp_pkt;

    packet_pack_fifo #(
        .ADDR_W (4),
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt   (out_pkt),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Producer must hold its fields stable while stalled.
    always @(posedge clk) begin
        if (!reset && prev_stall && in_valid) begin
            compared++;
            assert (in_addr === prev_addr && in_data === prev_data) else begin
                mismatched++;
                $error("[TB] FAIL protocol_hold: observed 0x%0h%0h expected 0x%0h%0h",
                       in_addr, in_data, prev_addr, prev_data);
            end
        end
        prev_stall <= in_valid & ~in_ready;
        prev_addr  <= in_addr;
        prev_data  <= in_data;
    end

    initial begin
        prev_stall = 1'b0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_addr    = 4'h0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        clear_ovf  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_pkt", 32'(out_pkt), 32'h000);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single push, then pop it
        in_valid = 1'b1; in_addr = 4'hA; in_data = 8'h5C;
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_pkt", 32'(out_pkt), 32'hA5C);
        check("single_addr", 32'(out_addr), 32'hA);
        check("single_data", 32'(out_data), 32'h5C);
        check("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_pop_count", 32'(count), 32'd0);
        check("single_pop_valid", 32'(out_valid), 32'd0);

        // Fill to full, then attempt a fifth push
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 4'(i);
            in_data  = 8'(i * 8'h11);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_no_ovf_yet", 32'(overflow), 32'd0);
        in_addr = 4'h5; in_data = 8'h55;
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_in_ready", 32'(in_ready), 32'd0);

        // Clear collides with a new rejected attempt: set wins
        clear_ovf = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 32'd1);
        in_valid = 1'b0;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Drain; 0x555 must never appear
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_pkt = 12'(i * 12'h111);
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_pkt", 32'(out_pkt), 32'(exp_pkt));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // Simultaneous push and pop at count=2, crossing the pointer wrap
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_addr = 4'h3; in_data = 8'(k);
            exp_q.push_back({4'h3, 8'(k)});
            tick();
        end
        check("stream_pre_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 2; k < 12; k++) begin
            in_addr = 4'h3; in_data = 8'(k);
            exp_pkt = exp_q.pop_front();
            check("stream_pkt", 32'(out_pkt), 32'(exp_pkt));
            exp_q.push_back({4'h3, 8'(k)});
            tick();
            check("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            exp_pkt = exp_q.pop_front();
            check("stream_tail_pkt", 32'(out_pkt), 32'(exp_pkt));
            tick();
        end
        out_ready = 1'b0;
        check("stream_tail_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with three entries queued
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_addr = 4'h9; in_data = 8'(8'hE0 + k);
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_pkt", 32'(out_pkt), 32'h000);
        tick();
        reset = 1'b0;
        tick();
        in_valid = 1'b1; in_addr = 4'h7; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        check("post_rst_pkt", 32'(out_pkt), 32'h777);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
